// File: rtl/fp_pkg.sv
// Shared encodings for the FP multi-cycle issue slice: op selects, fflag positions, FSM states.
package fp_pkg;

  localparam logic FP_OP_DIV  = 1'b0;
  localparam logic FP_OP_SQRT = 1'b1;

  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } mc_state_e;

  // Quiet NaN with only the MSB of the fraction set; callers slice to FLEN.
  function automatic logic [63:0] canonical_nan(input int unsigned flen);
    return (flen == 64) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
  endfunction

endpackage

// File: rtl/fp_mc_watchdog.sv
// Cycle counter for the WAIT state; expire flags the last permitted cycle without done.
module fp_mc_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CntLast)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = enable && (cnt_q == CntLast);

endmodule

// File: rtl/fp_mc_issue.sv
// Initiator for FDIV/FSQRT start/done units: one op in flight, operands held until done,
// result returned on a registered valid/ready response port.
module fp_mc_issue
  import fp_pkg::*;
#(
  parameter int unsigned FLEN           = 32,
  parameter int unsigned TAG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [2:0]       req_rm,
  input  logic [FLEN-1:0]  req_a,
  input  logic [FLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             busy,
  output logic             div_start,
  output logic [2:0]       div_rm,
  output logic [FLEN-1:0]  div_a,
  output logic [FLEN-1:0]  div_b,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic [FLEN-1:0]  div_result,
  input  logic [4:0]       div_fflags,
  output logic             sqrt_start,
  output logic [2:0]       sqrt_rm,
  output logic [FLEN-1:0]  sqrt_operand,
  input  logic             sqrt_busy,
  input  logic             sqrt_done,
  input  logic [FLEN-1:0]  sqrt_result,
  input  logic             sqrt_nv,
  input  logic             sqrt_nx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [FLEN-1:0]  rsp_result,
  output logic [4:0]       rsp_fflags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout
);

  localparam logic [63:0] NanWide = canonical_nan(FLEN);

  mc_state_e        state_q;
  logic             op_q;
  logic [2:0]       rm_q;
  logic [FLEN-1:0]  a_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic             kill_q;
  logic             ready_en_q;
  logic             rsp_valid_q, rsp_timeout_q;
  logic [FLEN-1:0]  rsp_result_q;
  logic [4:0]       rsp_fflags_q;

  logic [FLEN-1:0] nan_val;
  logic            sel_busy, sel_done, start_ok, wd_expire;

  assign nan_val  = NanWide[FLEN-1:0];
  assign sel_busy = (op_q == FP_OP_SQRT) ? sqrt_busy : div_busy;
  assign sel_done = (op_q == FP_OP_SQRT) ? sqrt_done : div_done;
  // A flush seen in ISSUE wins over start: the op is dropped before the unit ever sees it.
  assign start_ok = (state_q == StIssue) && !sel_busy && !flush;

  fp_mc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .enable(state_q == StWait),
    .expire(wd_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= FP_OP_DIV;
      rm_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      tag_q         <= '0;
      kill_q        <= 1'b0;
      ready_en_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_result_q  <= '0;
      rsp_fflags_q  <= '0;
    end else begin
      ready_en_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            op_q    <= req_op;
            rm_q    <= req_rm;
            a_q     <= req_a;
            b_q     <= req_b;
            tag_q   <= req_tag;
            kill_q  <= 1'b0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (!sel_busy) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (flush) begin
            kill_q <= 1'b1;
          end
          if (sel_done || wd_expire) begin
            if (kill_q || flush) begin
              kill_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              rsp_valid_q <= 1'b1;
              tag_q       <= tag_q;
              state_q     <= StResp;
              if (sel_done) begin
                rsp_timeout_q <= 1'b0;
                rsp_result_q  <= (op_q == FP_OP_SQRT) ? sqrt_result : div_result;
                rsp_fflags_q  <= (op_q == FP_OP_SQRT) ? {sqrt_nv, 3'b000, sqrt_nx} : div_fflags;
              end else begin
                rsp_timeout_q <= 1'b1;
                rsp_result_q  <= nan_val;
                rsp_fflags_q  <= 5'b1 << FFLAG_NV;
              end
            end
          end
        end
        StResp: begin
          if (flush || rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready    = (state_q == StIdle) && ready_en_q && !flush;
  assign busy         = (state_q != StIdle);
  assign div_start    = start_ok && (op_q == FP_OP_DIV);
  assign sqrt_start   = start_ok && (op_q == FP_OP_SQRT);
  assign div_rm       = rm_q;
  assign div_a        = a_q;
  assign div_b        = b_q;
  assign sqrt_rm      = rm_q;
  assign sqrt_operand = a_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_fflags   = rsp_fflags_q;
  assign rsp_tag      = tag_q;
  assign rsp_timeout  = rsp_timeout_q;

endmodule

// File: tb/tb_fp_mc_issue.sv
// Directed bench for fp_mc_issue: sqrt/div paths, backpressure, flush, watchdog, reset.
module tb_fp_mc_issue;

  localparam int unsigned FLEN  = 32;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_op;
  logic [2:0]       req_rm;
  logic [FLEN-1:0]  req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush, busy;
  logic             div_start, div_busy, div_done;
  logic [2:0]       div_rm;
  logic [FLEN-1:0]  div_a, div_b, div_result;
  logic [4:0]       div_fflags;
  logic             sqrt_start, sqrt_busy, sqrt_done, sqrt_nv, sqrt_nx;
  logic [2:0]       sqrt_rm;
  logic [FLEN-1:0]  sqrt_operand, sqrt_result;
  logic             rsp_valid, rsp_ready, rsp_timeout;
  logic [FLEN-1:0]  rsp_result;
  logic [4:0]       rsp_fflags;
  logic [TAG_W-1:0] rsp_tag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_mc_issue #(
    .FLEN          (FLEN),
    .TAG_W         (TAG_W),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rm      (req_rm),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .flush       (flush),
    .busy        (busy),
    .div_start   (div_start),
    .div_rm      (div_rm),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_busy    (div_busy),
    .div_done    (div_done),
    .div_result  (div_result),
    .div_fflags  (div_fflags),
    .sqrt_start  (sqrt_start),
    .sqrt_rm     (sqrt_rm),
    .sqrt_operand(sqrt_operand),
    .sqrt_busy   (sqrt_busy),
    .sqrt_done   (sqrt_done),
    .sqrt_result (sqrt_result),
    .sqrt_nv     (sqrt_nv),
    .sqrt_nx     (sqrt_nx),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_fflags  (rsp_fflags),
    .rsp_tag     (rsp_tag),
    .rsp_timeout (rsp_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the ISSUE cycle with settled outputs.
  task automatic issue(input logic op, input logic [2:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_rm    = rm;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    #1;
    chk("req_ready_idle", req_ready, 1);
    next();
    req_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_op = 0; req_rm = 0; req_a = 0; req_b = 0; req_tag = 0;
    flush = 0; rsp_ready = 0;
    div_busy = 0; div_done = 0; div_result = 0; div_fflags = 0;
    sqrt_busy = 0; sqrt_done = 0; sqrt_result = 0; sqrt_nv = 0; sqrt_nx = 0;

    next(); next();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    #1;
    chk("rel_req_ready_same", req_ready, 0);
    next();
    #1;
    chk("rel_req_ready_next", req_ready, 1);
    flush = 1'b1;
    #1;
    chk("idle_flush_ready", req_ready, 0);
    flush = 1'b0;

    // 1: FSQRT 4.0 -> 2.0, done 16 cycles after start
    issue(1'b1, 3'b000, 32'h4080_0000, 32'h0, 5'd7);
    chk("t1_sqrt_start", sqrt_start, 1);
    chk("t1_div_start", div_start, 0);
    chk("t1_busy", busy, 1);
    chk("t1_req_ready", req_ready, 0);
    chk("t1_operand", sqrt_operand, 32'h4080_0000);
    next(); #1;
    chk("t1_start_one_cycle", sqrt_start, 0);
    for (int i = 0; i < 14; i++) next();
    sqrt_done = 1'b1; sqrt_result = 32'h4000_0000;
    #1;
    chk("t1_rsp_before", rsp_valid, 0);
    chk("t1_operand_held", sqrt_operand, 32'h4080_0000);
    next();
    sqrt_done = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_result", rsp_result, 32'h4000_0000);
    chk("t1_fflags", rsp_fflags, 0);
    chk("t1_tag", rsp_tag, 7);
    chk("t1_timeout", rsp_timeout, 0);
    next();
    rsp_ready = 1'b0;
    #1;
    chk("t1_rsp_drop", rsp_valid, 0);
    chk("t1_ready_after", req_ready, 1);

    // 2: FSQRT -1.0 -> NaN with NV
    issue(1'b1, 3'b001, 32'hBF80_0000, 32'h0, 5'd2);
    chk("t2_sqrt_rm", sqrt_rm, 3'b001);
    next(); next(); next();
    sqrt_done = 1'b1; sqrt_result = 32'h7FC0_0000; sqrt_nv = 1'b1;
    next();
    sqrt_done = 1'b0; sqrt_nv = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_result", rsp_result, 32'h7FC0_0000);
    chk("t2_fflags", rsp_fflags, 5'b10000);
    next();
    rsp_ready = 1'b0;

    // 3: FDIV 1.0/0.0 with 5 cycles of backpressure
    issue(1'b0, 3'b010, 32'h3F80_0000, 32'h0000_0000, 5'd3);
    chk("t3_div_start", div_start, 1);
    chk("t3_sqrt_start", sqrt_start, 0);
    chk("t3_div_a", div_a, 32'h3F80_0000);
    chk("t3_div_b", div_b, 32'h0);
    chk("t3_div_rm", div_rm, 3'b010);
    next(); next();
    div_done = 1'b1; div_result = 32'h7F80_0000; div_fflags = 5'b01000;
    next();
    div_done = 1'b0; div_result = 32'h1234_5678; div_fflags = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_result", rsp_result, 32'h7F80_0000);
      chk("t3_hold_fflags", rsp_fflags, 5'b01000);
      chk("t3_hold_tag", rsp_tag, 3);
      next();
    end
    rsp_ready = 1'b1;
    next();
    rsp_ready = 1'b0;
    #1;
    chk("t3_rsp_drop", rsp_valid, 0);

    // 4: flush three cycles into WAIT discards the result
    issue(1'b0, 3'b000, 32'h4000_0000, 32'h3F80_0000, 5'd9);
    next(); next(); next();
    flush = 1'b1;
    next();
    flush = 1'b0;
    #1;
    chk("t4_busy_after_flush", busy, 1);
    chk("t4_ready_low", req_ready, 0);
    next();
    div_done = 1'b1; div_result = 32'h4000_0000; div_fflags = 0;
    #1;
    chk("t4_no_rsp_at_done", rsp_valid, 0);
    next();
    div_done = 1'b0;
    #1;
    chk("t4_no_rsp", rsp_valid, 0);
    chk("t4_idle", busy, 0);
    chk("t4_ready", req_ready, 1);

    // 5: no done -> watchdog response 64 cycles after start
    issue(1'b1, 3'b000, 32'h4100_0000, 32'h0, 5'd4);
    chk("t5_start", sqrt_start, 1);
    for (int i = 0; i < 64; i++) next();
    #1;
    chk("t5_not_yet", rsp_valid, 0);
    next();
    rsp_ready = 1'b1;
    #1;
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_timeout", rsp_timeout, 1);
    chk("t5_nan", rsp_result, 32'h7FC0_0000);
    chk("t5_fflags", rsp_fflags, 5'b10000);
    chk("t5_tag", rsp_tag, 4);
    next();
    rsp_ready = 1'b0;
    sqrt_busy = 1'b1;
    issue(1'b1, 3'b000, 32'h4180_0000, 32'h0, 5'd5);
    chk("t5_busy_nostart", sqrt_start, 0);
    next(); #1;
    chk("t5_busy_nostart2", sqrt_start, 0);
    chk("t5_still_busy", busy, 1);
    next();
    sqrt_busy = 1'b0;
    #1;
    chk("t5_start_after_busy", sqrt_start, 1);
    next();
    div_done = 1'b1;
    next();
    div_done = 1'b0;
    #1;
    chk("t5_other_done_ignored", rsp_valid, 0);

    // 6: reset in WAIT
    next();
    reset = 1'b1;
    next();
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_operand", sqrt_operand, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_sqrt_start", sqrt_start, 0);
    reset = 1'b0;
    #1;
    chk("t6_ready_release", req_ready, 0);
    next();
    #1;
    chk("t6_ready_after", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time limit reached");
    $fatal(1, "time limit");
  end

endmodule
